// File: rtl/global_avgpool_8x8_64ch_requant.sv
// Global average pool over each HxW pooled map: triggers the upstream max-pool, streams its
// whole volume, and keeps one rounded, clamped average per channel in a register file.
module global_avgpool_8x8_64ch_requant #(
    parameter int CHANNELS = 64,
    parameter int H        = 8,
    parameter int W        = 8,
    parameter int DATA_W   = 4,
    parameter int SHIFT    = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [4:0]        input_image_index,
    input  logic [31:0]       read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic              upstream_start,
    output logic [4:0]        upstream_image_index,
    input  logic              upstream_done,
    output logic [31:0]       upstream_read_addr,
    input  logic [DATA_W-1:0] upstream_read_data
);

    localparam int PIX   = H * W;
    localparam int TOTAL = CHANNELS * PIX;
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int RND_W = ACC_W + 1;
    localparam logic [31:0]       LAST_ADDR = 32'(TOTAL - 1);
    localparam logic [SHIFT-1:0]  LAST_PIX  = SHIFT'(PIX - 1);
    localparam logic [SHIFT-1:0]  PIX_ONE   = SHIFT'(32'd1);
    localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(32'd1);
    localparam logic [DATA_W-1:0] MAX_VAL   = {DATA_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UP_START = 3'd1,
        S_UP_WAIT  = 3'd2,
        S_ACCUM    = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              state_r, state_next;
    logic [31:0]         addr_r, addr_next;
    logic                clear_cnt_s;
    logic                valid_r;
    logic                busy_r, done_r, ustart_r;
    logic [ACC_W-1:0]    acc_r, acc_sum_s;
    logic [SHIFT-1:0]    pix_r;
    logic [CH_W-1:0]     ch_r;
    logic [DATA_W-1:0]   result_r [CHANNELS];

    // Round half up by adding half an LSB before the shift, then saturate to the element range.
    function automatic logic [DATA_W-1:0] round_clamp(input logic [ACC_W-1:0] sum);
        logic [RND_W-1:0] scaled;
        scaled = (RND_W'(sum) + RND_W'(32'd1 << (SHIFT - 1))) >> SHIFT;
        if (scaled > RND_W'(MAX_VAL)) begin
            return MAX_VAL;
        end else begin
            return scaled[DATA_W-1:0];
        end
    endfunction

    assign busy                 = busy_r;
    assign done                 = done_r;
    assign upstream_start       = ustart_r;
    assign upstream_read_addr   = addr_r;
    assign upstream_image_index = input_image_index;

    // Next-state and address-issue logic.
    always_comb begin
        state_next  = state_r;
        addr_next   = addr_r;
        clear_cnt_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) state_next = S_UP_START;
                else       state_next = S_IDLE;
            end
            S_UP_START: state_next = S_UP_WAIT;
            S_UP_WAIT: begin
                if (upstream_done) begin
                    state_next  = S_ACCUM;
                    addr_next   = 32'd0;
                    clear_cnt_s = 1'b1;
                end else begin
                    state_next = S_UP_WAIT;
                end
            end
            S_ACCUM: begin
                if (addr_r == LAST_ADDR) state_next = S_DRAIN;
                else                     addr_next  = addr_r + 32'd1;
            end
            // Stay until the last in-flight datum has been folded in.
            S_DRAIN: begin
                if (valid_r) state_next = S_DRAIN;
                else         state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State and registered control outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= S_IDLE;
            addr_r   <= 32'd0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ustart_r <= 1'b0;
        end else begin
            state_r  <= state_next;
            addr_r   <= addr_next;
            valid_r  <= (state_r == S_ACCUM);
            busy_r   <= (state_next != S_IDLE) && (state_next != S_DONE);
            done_r   <= (state_next == S_DONE);
            ustart_r <= (state_next == S_UP_START);
        end
    end

    // First pixel of a channel loads the accumulator instead of adding to it.
    always_comb begin
        if (pix_r == '0) acc_sum_s = ACC_W'(upstream_read_data);
        else             acc_sum_s = acc_r + ACC_W'(upstream_read_data);
    end

    // Accumulate returning data and commit one averaged result per channel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r <= '0;
            pix_r <= '0;
            ch_r  <= '0;
            for (int i = 0; i < CHANNELS; i++) result_r[i] <= '0;
        end else if (clear_cnt_s) begin
            acc_r <= '0;
            pix_r <= '0;
            ch_r  <= '0;
        end else if (valid_r) begin
            acc_r <= acc_sum_s;
            pix_r <= pix_r + PIX_ONE;
            if (pix_r == LAST_PIX) begin
                result_r[ch_r] <= round_clamp(acc_sum_s);
                ch_r           <= ch_r + CH_ONE;
            end
        end
    end

    // Result read port, zero outside the vector.
    always_comb begin
        read_data = '0;
        if (read_addr < 32'(CHANNELS)) read_data = result_r[read_addr[CH_W-1:0]];
        else                           read_data = '0;
    end

endmodule

// File: tb/tb_global_avgpool_8x8_64ch_requant.sv
// Randomized bench: a BRAM-like upstream model feeds the pool; per-channel averages are
// recomputed from the memory image with plain arithmetic and compared through the read port.
module tb_global_avgpool_8x8_64ch_requant;

    logic        clk = 1'b0;
    logic        resetn, start, upstream_done;
    logic [4:0]  input_image_index, upstream_image_index;
    logic [31:0] read_addr, upstream_read_addr;
    logic [3:0]  read_data, upstream_read_data;
    logic        busy, done, upstream_start;

    logic [3:0]  mem [4096];
    int err_cnt = 0;
    int chk_cnt = 0;
    int us_cnt  = 0;

    always #5 clk = ~clk;

    global_avgpool_8x8_64ch_requant dut (
        .clk(clk), .resetn(resetn), .start(start), .input_image_index(input_image_index),
        .read_addr(read_addr), .read_data(read_data), .busy(busy), .done(done),
        .upstream_start(upstream_start), .upstream_image_index(upstream_image_index),
        .upstream_done(upstream_done), .upstream_read_addr(upstream_read_addr),
        .upstream_read_data(upstream_read_data)
    );

    // Upstream BRAM port B: one registered cycle of read latency.
    always @(posedge clk) upstream_read_data <= mem[upstream_read_addr[11:0]];

    always @(posedge clk) if (upstream_start === 1'b1) us_cnt <= us_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_avg(input int ch);
        int sum, q;
        sum = 0;
        for (int p = 0; p < 64; p++) sum += int'(mem[ch * 64 + p]);
        q = (sum + 32) / 64;
        return (q > 15) ? 15 : q;
    endfunction

    // mode 0: constant 15, 1: ch mod 16, 2: alternating 0/1, 3: random with channel 5 summing to target
    task automatic fill(input int mode, input int target);
        int rem, v;
        for (int a = 0; a < 4096; a++) begin
            case (mode)
                0: mem[a] = 4'd15;
                1: mem[a] = 4'((a / 64) % 16);
                2: mem[a] = 4'(a % 2);
                default: mem[a] = 4'($urandom_range(0, 15));
            endcase
        end
        if (mode == 3) begin
            rem = target;
            for (int p = 0; p < 64; p++) begin
                v = (rem > 15) ? 15 : rem;
                mem[5 * 64 + p] = 4'(v);
                rem -= v;
            end
        end
    endtask

    task automatic check_results(input string tag);
        for (int ch = 0; ch < 64; ch++) begin
            read_addr = 32'(ch);
            #1;
            check_val($sformatf("%s_ch%0d", tag, ch), 32'(read_data), 32'(ref_avg(ch)));
        end
        read_addr = 32'd64;
        #1;
        check_val("read_addr_64", 32'(read_data), 32'd0);
        read_addr = 32'd1000;
        #1;
        check_val("read_addr_1000", 32'(read_data), 32'd0);
    endtask

    task automatic run_pass(input string tag, input bit stray);
        int base, lat;
        base = us_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, "_ustart_hi"}, 32'(upstream_start), 32'd1);
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        check_val({tag, "_ustart_lo"}, 32'(upstream_start), 32'd0);
        if (stray) begin
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (19) step();
        end else begin
            repeat (20) step();
        end
        upstream_done = 1'b1;
        step();
        upstream_done = 1'b0;
        check_val({tag, "_first_addr"}, upstream_read_addr, 32'd0);
        lat = 0;
        while (lat < 5000) begin
            start = stray && (lat == 2000);
            step();
            lat++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        check_val({tag, "_done_latency"}, 32'(lat), 32'd4098);
        check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        repeat (4) step();
        check_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_ustart_count"}, 32'(us_cnt - base), 32'd1);
    endtask

    initial begin
        int n, dcnt;
        int round_sum [4] = '{31, 32, 95, 96};
        int round_exp [4] = '{0, 1, 1, 2};
        resetn = 1'b0;
        start = 1'b0;
        upstream_done = 1'b0;
        read_addr = 32'd0;
        input_image_index = 5'($urandom_range(0, 31));
        fill(3, 0);
        repeat (3) step();
        resetn = 1'b1;
        repeat (2) step();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_ustart", 32'(upstream_start), 32'd0);
        check_val("rst_uaddr", upstream_read_addr, 32'd0);
        check_val("img_index", 32'(upstream_image_index), 32'(input_image_index));
        for (int ch = 0; ch < 64; ch++) begin
            read_addr = 32'(ch);
            #1;
            check_val($sformatf("rst_res%0d", ch), 32'(read_data), 32'd0);
        end

        fill(0, 0);
        run_pass("const15", 1'b1);
        check_results("const15");
        fill(1, 0);
        run_pass("chmod", 1'b0);
        check_results("chmod");
        fill(2, 0);
        run_pass("alt", 1'b0);
        check_results("alt");
        for (int i = 0; i < 4; i++) begin
            fill(3, round_sum[i]);
            run_pass($sformatf("round%0d", i), 1'b0);
            read_addr = 32'd5;
            #1;
            check_val($sformatf("round_ch5_sum%0d", round_sum[i]), 32'(read_data), 32'(round_exp[i]));
            check_results($sformatf("round%0d", i));
        end

        // Abort a pass mid-stream with an asynchronous reset.
        fill(3, 40);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (21) step();
        upstream_done = 1'b1;
        step();
        upstream_done = 1'b0;
        n = 0;
        while (upstream_read_addr != 32'd1500 && n < 3000) begin
            step();
            n++;
        end
        check_val("reach_1500", upstream_read_addr, 32'd1500);
        #2;
        resetn = 1'b0;
        read_addr = 32'd5;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_ustart", 32'(upstream_start), 32'd0);
        check_val("arst_uaddr", upstream_read_addr, 32'd0);
        check_val("arst_result", 32'(read_data), 32'd0);
        repeat (3) step();
        resetn = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 4200; c++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        check_val("no_done_after_reset", 32'(dcnt), 32'd0);
        fill(3, $urandom_range(0, 960));
        run_pass("after_reset", 1'b0);
        check_results("after_reset");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
